vga_line_fetch: RTL

- Upstream pixel source for the VGA display driver. Replaces its built-in test pattern with framebuffer content.
- Prefetches each display line from an external framebuffer memory over a req/ack word interface into a ping-pong line buffer.
- Streams 3-bit RGB pixels, synchronised to the driver's line_start/frame_start/pixel_en timing, to the driver's colour registers.

---
 rtl/vga_pkg.sv | 19 +
 rtl/vga_line_ram.sv | 27 ++
 rtl/vga_line_fetch.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA line-fetch slice: pixel packing, fetch FSM
// encoding and the words-per-line helper.
package vga_pkg;

  localparam int PIX_PER_WORD = 8;
  localparam int PIX_W        = 3;
  localparam int WORD_W       = PIX_PER_WORD * PIX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

  function automatic int wpl(input int h_pixels);
    return h_pixels / PIX_PER_WORD;
  endfunction

endpackage

// File: rtl/vga_line_ram.sv
// Ping-pong line buffer: two banks of WPL packed-pixel words, bank selected by
// the address MSB. Synchronous write, combinational read.
module vga_line_ram
  import vga_pkg::*;
#(
  parameter int WPL = 80,
  parameter int WW  = (WPL > 1) ? $clog2(WPL) : 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [WW:0]       wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [WW:0]       rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [0:1][0:WPL-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr[WW]][wr_addr[WW-1:0]] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr[WW]][rd_addr[WW-1:0]];

endmodule

// File: rtl/vga_line_fetch.sv
// Prefetches each display line from the framebuffer into a ping-pong buffer
// and streams registered 3-bit RGB pixels in step with the VGA driver timing.
module vga_line_fetch
  import vga_pkg::*;
#(
  parameter int                H_PIXELS = 640,
  parameter int                V_LINES  = 480,
  parameter int                ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] FB_BASE  = '0
) (
  input  logic              clk_60Mhz,
  input  logic              reset_,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic              pixel_en,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_data,
  output logic              o_r,
  output logic              o_g,
  output logic              o_b,
  output logic              o_underrun
);

  localparam int WPL = wpl(H_PIXELS);
  localparam int WW  = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int PCW = $clog2(H_PIXELS + 1);
  localparam int FLW = $clog2(V_LINES + 1);

  localparam logic [FLW-1:0]    V_END     = FLW'(V_LINES);
  localparam logic [PCW-1:0]    H_END     = PCW'(H_PIXELS);
  localparam logic [WW-1:0]     LAST_WORD = WW'(WPL - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(WPL);

  fetch_state_e      state_q, state_d;
  logic [WW-1:0]     word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [FLW-1:0]    fetch_line_q, fetch_line_d;
  logic              disp_sel_q, disp_sel_d;
  logic [PCW-1:0]    pix_cnt_q, pix_cnt_d;
  logic [PIX_W-1:0]  rgb_q, rgb_d;
  logic              underrun_q, underrun_d;

  logic              start_evt;
  logic              wr_en;
  logic [WORD_W-1:0] rd_data;

  always_ff @(posedge clk_60Mhz or negedge reset_) begin
    if (!reset_) begin
      state_q      <= IDLE;
      word_cnt_q   <= '0;
      mem_addr_q   <= '0;
      line_base_q  <= FB_BASE;
      fetch_line_q <= '0;
      disp_sel_q   <= 1'b0;
      pix_cnt_q    <= '0;
      rgb_q        <= '0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      mem_addr_q   <= mem_addr_d;
      line_base_q  <= line_base_d;
      fetch_line_q <= fetch_line_d;
      disp_sel_q   <= disp_sel_d;
      pix_cnt_q    <= pix_cnt_d;
      rgb_q        <= rgb_d;
      underrun_q   <= underrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    mem_addr_d   = mem_addr_q;
    line_base_d  = line_base_q;
    fetch_line_d = fetch_line_q;
    disp_sel_d   = disp_sel_q;
    pix_cnt_d    = pix_cnt_q;
    rgb_d        = '0;
    underrun_d   = underrun_q;
    wr_en        = 1'b0;
    start_evt    = frame_start | line_start;

    if (pixel_en && (pix_cnt_q < H_END)) begin
      rgb_d     = rd_data[PIX_W*pix_cnt_q[2:0] +: PIX_W];
      pix_cnt_d = pix_cnt_q + 1'b1;
    end

    // An ack coinciding with a start event belongs to the aborted fetch.
    if ((state_q == REQ) && mem_ack && !start_evt) begin
      wr_en      = 1'b1;
      word_cnt_d = word_cnt_q + 1'b1;
      mem_addr_d = mem_addr_q + 1'b1;
      if (word_cnt_q == LAST_WORD) begin
        state_d = DONE;
      end
    end

    if (frame_start) begin
      fetch_line_d = '0;
      line_base_d  = FB_BASE;
    end else if (line_start) begin
      if (state_q == REQ) begin
        underrun_d = 1'b1;
      end
      disp_sel_d = ~disp_sel_q;
      pix_cnt_d  = '0;
      if (fetch_line_q < V_END) begin
        fetch_line_d = fetch_line_q + 1'b1;
        line_base_d  = line_base_q + LINE_STEP;
      end
    end

    if (start_evt) begin
      word_cnt_d = '0;
      if (fetch_line_d < V_END) begin
        state_d    = REQ;
        mem_addr_d = line_base_d;
      end else begin
        state_d = IDLE;
      end
    end
  end

  vga_line_ram #(
    .WPL (WPL),
    .WW  (WW)
  ) u_line_ram (
    .clk     (clk_60Mhz),
    .wr_en   (wr_en),
    .wr_addr ({~disp_sel_q, word_cnt_q}),
    .wr_data (mem_data),
    .rd_addr ({disp_sel_q, WW'(pix_cnt_q >> 3)}),
    .rd_data (rd_data)
  );

  assign mem_req    = (state_q == REQ);
  assign mem_addr   = mem_addr_q;
  assign o_r        = rgb_q[0];
  assign o_g        = rgb_q[1];
  assign o_b        = rgb_q[2];
  assign o_underrun = underrun_q;

endmodule
